// File: rtl/wbu.sv
// Write-back unit: captures one retiring LSU result, commits it to the GPR/CSR
// files in a single cycle, then hands the next PC to the IFU with a valid/ready handshake.
module wbu (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_receive_valid,
  input  logic [31:0] wd,
  input  logic [31:0] csr_wd,
  input  logic [4:0]  rd,
  input  logic [1:0]  csr_rd,
  input  logic        reg_write_en,
  input  logic        csreg_write_en,
  input  logic        ecall,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic [31:0] instruction,
  input  logic        ifu_receive_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [1:0]  csr_rs,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [31:0] csr_src,
  output logic [31:0] mtvec_out,
  output logic        wbu_send_valid,
  output logic [31:0] npc,
  output logic        wbu_state
);

  localparam logic [1:0]  CSR_MSTATUS = 2'd0;
  localparam logic [1:0]  CSR_MTVEC   = 2'd1;
  localparam logic [1:0]  CSR_MEPC    = 2'd2;
  localparam logic [1:0]  CSR_MCAUSE  = 2'd3;

  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
  localparam logic [31:0] NPC_RST     = 32'h8000_0000;
  localparam logic [31:0] CAUSE_ECALL = 32'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    SEND   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] wd;
    logic [31:0] csr_wd;
    logic [4:0]  rd;
    logic [1:0]  csr_rd;
    logic        reg_write_en;
    logic        csreg_write_en;
    logic        ecall;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instruction;
  } txn_t;

  state_e      state_q, state_d;
  txn_t        txn_q, txn_d;
  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic [31:0] csr_q [4];
  logic [31:0] csr_d [4];
  logic [31:0] npc_q, npc_d;
  logic        send_valid_q, send_valid_d;

  // The encoding is kept with the transaction but nothing downstream consumes it.
  logic unused_instruction;
  assign unused_instruction = ^txn_q.instruction;

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    txn_d        = txn_q;
    gpr_d        = gpr_q;
    csr_d        = csr_q;
    npc_d        = npc_q;
    send_valid_d = send_valid_q;

    unique case (state_q)
      IDLE: begin
        if (wbu_receive_valid) begin
          txn_d.wd             = wd;
          txn_d.csr_wd         = csr_wd;
          txn_d.rd             = rd;
          txn_d.csr_rd         = csr_rd;
          txn_d.reg_write_en   = reg_write_en;
          txn_d.csreg_write_en = csreg_write_en;
          txn_d.ecall          = ecall;
          txn_d.pc             = pc;
          txn_d.pc_next        = pc_next;
          txn_d.instruction    = instruction;
          state_d              = COMMIT;
        end
      end

      COMMIT: begin
        if (txn_q.reg_write_en && (txn_q.rd != 5'd0)) begin
          gpr_d[txn_q.rd] = txn_q.wd;
        end
        if (txn_q.csreg_write_en) begin
          csr_d[txn_q.csr_rd] = txn_q.csr_wd;
        end
        // Applied after the explicit CSR write so the trap update takes priority.
        if (txn_q.ecall) begin
          csr_d[CSR_MEPC]   = txn_q.pc;
          csr_d[CSR_MCAUSE] = CAUSE_ECALL;
        end
        npc_d        = txn_q.pc_next;
        send_valid_d = 1'b1;
        state_d      = SEND;
      end

      SEND: begin
        if (ifu_receive_ready) begin
          send_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        send_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // NOTE: the register files are architecturally visible after reset, so every
  // entry is cleared here rather than left uninitialised like a plain RAM.
  // NOTE: state uses non-blocking assignments so all flops sample the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      txn_q        <= '0;
      npc_q        <= NPC_RST;
      send_valid_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
      csr_q[CSR_MSTATUS] <= MSTATUS_RST;
      csr_q[CSR_MTVEC]   <= '0;
      csr_q[CSR_MEPC]    <= '0;
      csr_q[CSR_MCAUSE]  <= '0;
    end else begin
      state_q      <= state_d;
      txn_q        <= txn_d;
      npc_q        <= npc_d;
      send_valid_q <= send_valid_d;
      gpr_q        <= gpr_d;
      csr_q        <= csr_d;
    end
  end

  // Reads see only committed state; a write lands on the following cycle.
  assign src1      = (rs1 == 5'd0) ? 32'd0 : gpr_q[rs1];
  assign src2      = (rs2 == 5'd0) ? 32'd0 : gpr_q[rs2];
  assign csr_src   = csr_q[csr_rs];
  assign mtvec_out = csr_q[CSR_MTVEC];

  assign wbu_send_valid = send_valid_q;
  assign npc            = npc_q;
  assign wbu_state      = (state_q != IDLE);

endmodule

// File: tb/tb_wbu.sv
// Directed testbench for wbu: reset values, GPR/CSR commits, ecall priority,
// IFU backpressure and reset aborting an in-flight commit.
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbu_receive_valid = 1'b0;
  logic [31:0] wd = '0, csr_wd = '0;
  logic [4:0]  rd = '0;
  logic [1:0]  csr_rd = '0;
  logic        reg_write_en = 1'b0, csreg_write_en = 1'b0, ecall = 1'b0;
  logic [31:0] pc = '0, pc_next = '0, instruction = '0;
  logic        ifu_receive_ready = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [1:0]  csr_rs = '0;
  logic [31:0] src1, src2, csr_src, mtvec_out, npc;
  logic        wbu_send_valid, wbu_state;

  int passed = 0;
  int total  = 0;

  wbu dut (
    .clk               (clk),
    .rst               (rst),
    .wbu_receive_valid (wbu_receive_valid),
    .wd                (wd),
    .csr_wd            (csr_wd),
    .rd                (rd),
    .csr_rd            (csr_rd),
    .reg_write_en      (reg_write_en),
    .csreg_write_en    (csreg_write_en),
    .ecall             (ecall),
    .pc                (pc),
    .pc_next           (pc_next),
    .instruction       (instruction),
    .ifu_receive_ready (ifu_receive_ready),
    .rs1               (rs1),
    .rs2               (rs2),
    .csr_rs            (csr_rs),
    .src1              (src1),
    .src2              (src2),
    .csr_src           (csr_src),
    .mtvec_out         (mtvec_out),
    .wbu_send_valid    (wbu_send_valid),
    .npc               (npc),
    .wbu_state         (wbu_state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wbu_receive_valid = 1'b0;
    wd = '0; csr_wd = '0; rd = '0; csr_rd = '0;
    reg_write_en = 1'b0; csreg_write_en = 1'b0; ecall = 1'b0;
    pc = '0; pc_next = '0; instruction = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rs1 = 5'd5; csr_rs = 2'd0;
    #1;
    total++; if (src1 !== 32'h0) $display("FAIL reset_src1: got %h want %h", src1, 32'h0); else passed++;
    total++; if (csr_src !== 32'h0000_1800) $display("FAIL reset_mstatus: got %h want %h", csr_src, 32'h0000_1800); else passed++;
    total++; if (npc !== 32'h8000_0000) $display("FAIL reset_npc: got %h want %h", npc, 32'h8000_0000); else passed++;
    total++; if (wbu_state !== 1'b0) $display("FAIL reset_state: got %b want 0", wbu_state); else passed++;
    total++; if (wbu_send_valid !== 1'b0) $display("FAIL reset_send_valid: got %b want 0", wbu_send_valid); else passed++;
    total++; if (mtvec_out !== 32'h0) $display("FAIL reset_mtvec: got %h want %h", mtvec_out, 32'h0); else passed++;
  endtask

  task automatic test_gpr_write();
    ifu_receive_ready = 1'b1;
    rs1 = 5'd3; rs2 = 5'd3;
    rd = 5'd3; wd = 32'hDEAD_BEEF; reg_write_en = 1'b1;
    pc = 32'h8000_0000; pc_next = 32'h8000_0004; instruction = 32'h0000_0013;
    wbu_receive_valid = 1'b1;
    tick();                       // capture edge: now in COMMIT
    clear_inputs();
    total++; if (wbu_state !== 1'b1) $display("FAIL gpr_commit_state: got %b want 1", wbu_state); else passed++;
    total++; if (wbu_send_valid !== 1'b0) $display("FAIL gpr_commit_valid: got %b want 0", wbu_send_valid); else passed++;
    total++; if (src1 !== 32'h0) $display("FAIL gpr_old_value: got %h want %h", src1, 32'h0); else passed++;
    tick();                       // commit edge: now in SEND
    total++; if (wbu_send_valid !== 1'b1) $display("FAIL gpr_send_valid: got %b want 1", wbu_send_valid); else passed++;
    total++; if (npc !== 32'h8000_0004) $display("FAIL gpr_npc: got %h want %h", npc, 32'h8000_0004); else passed++;
    total++; if (src1 !== 32'hDEAD_BEEF) $display("FAIL gpr_src1: got %h want %h", src1, 32'hDEAD_BEEF); else passed++;
    total++; if (src2 !== 32'hDEAD_BEEF) $display("FAIL gpr_src2_same_addr: got %h want %h", src2, 32'hDEAD_BEEF); else passed++;
    tick();                       // handshake edge: back to IDLE
    total++; if (wbu_state !== 1'b0) $display("FAIL gpr_idle_state: got %b want 0", wbu_state); else passed++;
    total++; if (wbu_send_valid !== 1'b0) $display("FAIL gpr_valid_drop: got %b want 0", wbu_send_valid); else passed++;
  endtask

  task automatic test_x0_write();
    rs1 = 5'd0; rs2 = 5'd3;
    rd = 5'd0; wd = 32'h0000_1234; reg_write_en = 1'b1; pc_next = 32'h8000_0008;
    wbu_receive_valid = 1'b1;
    tick();
    clear_inputs();
    tick();
    total++; if (src1 !== 32'h0) $display("FAIL x0_src1: got %h want %h", src1, 32'h0); else passed++;
    total++; if (src2 !== 32'hDEAD_BEEF) $display("FAIL x0_other_reg: got %h want %h", src2, 32'hDEAD_BEEF); else passed++;
    total++; if (npc !== 32'h8000_0008) $display("FAIL x0_npc: got %h want %h", npc, 32'h8000_0008); else passed++;
    tick();
  endtask

  task automatic test_csr_write();
    csr_rs = 2'd1;
    csr_rd = 2'd1; csr_wd = 32'h8000_0100; csreg_write_en = 1'b1; pc_next = 32'h8000_000C;
    wbu_receive_valid = 1'b1;
    tick();
    clear_inputs();
    total++; if (mtvec_out !== 32'h0) $display("FAIL csr_old_mtvec: got %h want %h", mtvec_out, 32'h0); else passed++;
    tick();
    total++; if (mtvec_out !== 32'h8000_0100) $display("FAIL csr_mtvec_out: got %h want %h", mtvec_out, 32'h8000_0100); else passed++;
    total++; if (csr_src !== 32'h8000_0100) $display("FAIL csr_src_mtvec: got %h want %h", csr_src, 32'h8000_0100); else passed++;
    tick();
  endtask

  // ecall together with a conflicting explicit write to mepc: the trap value must win.
  task automatic test_ecall();
    pc = 32'h8000_0010; pc_next = 32'h8000_0100; ecall = 1'b1;
    csreg_write_en = 1'b1; csr_rd = 2'd2; csr_wd = 32'hDEAD_0000;
    wbu_receive_valid = 1'b1;
    tick();
    clear_inputs();
    tick();
    csr_rs = 2'd2;
    #1;
    total++; if (csr_src !== 32'h8000_0010) $display("FAIL ecall_mepc: got %h want %h", csr_src, 32'h8000_0010); else passed++;
    csr_rs = 2'd3;
    #1;
    total++; if (csr_src !== 32'd11) $display("FAIL ecall_mcause: got %h want %h", csr_src, 32'd11); else passed++;
    csr_rs = 2'd0;
    #1;
    total++; if (csr_src !== 32'h0000_1800) $display("FAIL ecall_mstatus: got %h want %h", csr_src, 32'h0000_1800); else passed++;
    total++; if (npc !== 32'h8000_0100) $display("FAIL ecall_npc: got %h want %h", npc, 32'h8000_0100); else passed++;
    total++; if (mtvec_out !== 32'h8000_0100) $display("FAIL ecall_mtvec_kept: got %h want %h", mtvec_out, 32'h8000_0100); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    ifu_receive_ready = 1'b0;
    rs1 = 5'd4; rs2 = 5'd5;
    rd = 5'd4; wd = 32'hA5A5_A5A5; reg_write_en = 1'b1; pc_next = 32'h8000_0200;
    wbu_receive_valid = 1'b1;
    tick();
    clear_inputs();
    tick();
    // A new request while stalled in SEND must not be taken.
    rd = 5'd5; wd = 32'h1111_1111; reg_write_en = 1'b1; pc_next = 32'h0000_0099;
    wbu_receive_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (wbu_send_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b want 1", i, wbu_send_valid); else passed++;
      total++; if (npc !== 32'h8000_0200) $display("FAIL bp_npc_%0d: got %h want %h", i, npc, 32'h8000_0200); else passed++;
      tick();
    end
    clear_inputs();
    ifu_receive_ready = 1'b1;
    tick();
    total++; if (wbu_state !== 1'b0) $display("FAIL bp_release_state: got %b want 0", wbu_state); else passed++;
    total++; if (wbu_send_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", wbu_send_valid); else passed++;
    total++; if (src1 !== 32'hA5A5_A5A5) $display("FAIL bp_gpr4: got %h want %h", src1, 32'hA5A5_A5A5); else passed++;
    total++; if (src2 !== 32'h0) $display("FAIL bp_ignored_gpr5: got %h want %h", src2, 32'h0); else passed++;
  endtask

  task automatic test_reset_mid_op();
    ifu_receive_ready = 1'b1;
    rs1 = 5'd7;
    rd = 5'd7; wd = 32'h7777_7777; reg_write_en = 1'b1; pc_next = 32'h8000_0300;
    wbu_receive_valid = 1'b1;
    tick();                       // now in COMMIT
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (wbu_state !== 1'b0) $display("FAIL rstmid_state: got %b want 0", wbu_state); else passed++;
    total++; if (wbu_send_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", wbu_send_valid); else passed++;
    total++; if (src1 !== 32'h0) $display("FAIL rstmid_gpr7: got %h want %h", src1, 32'h0); else passed++;
    total++; if (npc !== 32'h8000_0000) $display("FAIL rstmid_npc: got %h want %h", npc, 32'h8000_0000); else passed++;
    tick();
    total++; if (src1 !== 32'h0) $display("FAIL rstmid_gpr7_later: got %h want %h", src1, 32'h0); else passed++;
    total++; if (wbu_state !== 1'b0) $display("FAIL rstmid_state_later: got %b want 0", wbu_state); else passed++;
  endtask

  initial begin
    test_reset();
    test_gpr_write();
    test_x0_write();
    test_csr_write();
    test_ecall();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 wbu_receive_valid  input  1  upstream LSU result valid; single-cycle pulse or level.
REQ-004 wd, csr_wd  input  32 each  GPR and CSR write data from the LSU.
REQ-005 rd  input  5  destination GPR index.
REQ-006 csr_rd  input  2  destination CSR: 0=mstatus, 1=mtvec, 2=mepc, 3=mcause.
REQ-007 reg_write_en, csreg_write_en, ecall  input  1 each  GPR write, CSR write, environment call.
REQ-008 pc, pc_next, instruction  input  32 each  retiring instruction's PC, next PC and encoding.
REQ-009 ifu_receive_ready  input  1  IFU ready to accept the next PC.
REQ-010 rs1, rs2  input  5 each  IDU GPR read addresses.
REQ-011 csr_rs  input  2  IDU CSR read address; same encoding as csr_rd.
REQ-012 src1, src2  output  32 each  combinational GPR read data.
REQ-013 csr_src, mtvec_out  output  32 each  combinational CSR read data and current mtvec.
REQ-014 wbu_send_valid  output  1  retired; npc is valid.
REQ-015 npc  output  32  registered next PC to the IFU.
REQ-016 wbu_state  output  1  high whenever state is not IDLE.

Function
REQ-017 wbu SHALL contain 32x32 GPRs and 4x32 CSRs.
REQ-018 x0 SHALL read as 0; writes to x0 SHALL be discarded.
REQ-019 The FSM SHALL use states IDLE, COMMIT and SEND, registered with next-state logic.
REQ-020 IDLE: when wbu_receive_valid=1, the FSM SHALL capture all inputs into internal registers and move to COMMIT; otherwise it SHALL stay in IDLE.
REQ-021 COMMIT: the block SHALL, in one cycle, perform the writes below from captured values, load npc=captured pc_next, and move to SEND.
REQ-022 COMMIT writes SHALL be:
- if reg_write_en: GPR[rd]<=wd.
- if csreg_write_en: CSR[csr_rd]<=csr_wd.
- if ecall: mepc<=pc and mcause<=32'd11.
REQ-023 When ecall=1 and csreg_write_en=1 target the same CSR in one commit, the ecall write SHALL win.
REQ-024 SEND: wbu_send_valid SHALL be 1 and npc SHALL be held stable until ifu_receive_ready=1, then the FSM SHALL go to IDLE; wbu_send_valid SHALL deassert on the following cycle.
REQ-025 Latency: receive at edge T -> registers written at edge T+1 -> wbu_send_valid high from T+1 -> earliest return to IDLE at edge T+2.
REQ-026 wbu_receive_valid SHALL be ignored outside IDLE; upstream holds its result until wbu_state=0.
REQ-027 Reads SHALL be combinational with no write bypass; a read in the same cycle as a write SHALL return the old value, and the new value from the next cycle.
REQ-028 rs1=rs2=rd SHALL be legal; both ports return the same value.
REQ-029 wbu_state SHALL be (state != IDLE).

Reset
REQ-030 On rst=1, state SHALL go to IDLE, all GPRs to 0, mstatus to 32'h00001800, and mtvec, mepc, mcause to 0.
REQ-031 On rst=1, wbu_send_valid SHALL go to 0 and npc to 32'h80000000.
REQ-032 Reset asserted in COMMIT or SEND SHALL abort the transaction; writes SHALL NOT be committed on that edge, and the FSM SHALL return to IDLE.

Verification
REQ-033 Post-reset: src1 for rs1=5 is 0; csr_src for csr_rs=0 is 32'h1800; npc=32'h80000000; wbu_state=0.
REQ-034 GPR write: rd=3, wd=32'hDEADBEEF, reg_write_en=1, pc_next=32'h80000004 -> src1(rs1=3)=DEADBEEF one cycle after COMMIT; wbu_send_valid with npc=80000004.
REQ-035 x0 write: rd=0, wd=32'h1234, reg_write_en=1 -> src1(rs1=0) stays 0.
REQ-036 ecall: pc=32'h80000010, ecall=1, mtvec preset 32'h80000100, pc_next=32'h80000100 -> mepc=80000010, mcause=11, npc=80000100.
REQ-037 Backpressure: ifu_receive_ready=0 for 3 cycles -> wbu_send_valid and npc stay stable, and a second wbu_receive_valid is ignored; ready=1 -> IDLE next edge.
REQ-038 Reset mid-op: rst pulsed during COMMIT of rd=7 -> GPR7=0, state=IDLE, wbu_send_valid=0.
